// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Decodes ASCII command frames from the UART receiver into registered
//   switch and button images. The two frame types are:
//     "S" + 4 hex digits + CR/LF  -> switch image
//     "B" + 2 hex digits + CR/LF  -> button image
//   A malformed frame is dropped in full and raises a single error strobe.
//
// Parameters
//   DATA_WIDTH    byte width (only 8 is supported)
//   SWITCH_COUNT  switch image width, 1..16
//   BUTTON_COUNT  button image width, 1..8
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   ena          design enable; when low, all state holds and bytes are dropped
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte
//   switch_data  registered switch image
//   button_data  registered button image
//   sw_update    one-cycle pulse after switch_data is written
//   btn_update   one-cycle pulse after button_data is written
//   cmd_error    one-cycle pulse after a frame is rejected
module uart_cmd_parser #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SWITCH_COUNT = 16,
  parameter int unsigned BUTTON_COUNT = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ena,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [SWITCH_COUNT-1:0] switch_data,
  output logic [BUTTON_COUNT-1:0] button_data,
  output logic                    sw_update,
  output logic                    btn_update,
  output logic                    cmd_error
);

  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 3;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [CNT_W-1:0] SW_DIGITS  = CNT_W'(4);
  localparam logic [CNT_W-1:0] BTN_DIGITS = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIGITS  = 2'd1,
    ST_TERM    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  state_e                  state_q,   state_d;
  logic [ACC_W-1:0]        acc_q,     acc_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    cmd_sw_q,  cmd_sw_d;
  logic [SWITCH_COUNT-1:0] switch_q,  switch_d;
  logic [BUTTON_COUNT-1:0] button_q,  button_d;
  logic                    sw_upd_q,  sw_upd_d;
  logic                    btn_upd_q, btn_upd_d;
  logic                    err_q,     err_d;

  logic [7:0]       rx_byte;
  logic             is_hex;
  logic [3:0]       nibble;
  logic             is_term;
  logic             sw_in_range;
  logic             btn_in_range;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n_digits;

  assign rx_byte = 8'(rx_data);

  // ASCII hex digit decode; accepts both letter cases
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(rx_byte - 8'h30);
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(rx_byte - 8'h37);
    end else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(rx_byte - 8'h57);
    end
  end

  assign is_term = (rx_byte == CH_LF) || (rx_byte == CH_CR);

  // Value fits the image only if no accumulator bit above its width is set
  assign sw_in_range  = ((acc_q >> SWITCH_COUNT) == ACC_W'(0));
  assign btn_in_range = ((acc_q >> BUTTON_COUNT) == ACC_W'(0));

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign n_digits = cmd_sw_q ? SW_DIGITS : BTN_DIGITS;

  // Next-state and commit logic; one byte consumed per enabled rx_valid
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cmd_sw_d  = cmd_sw_q;
    switch_d  = switch_q;
    button_d  = button_q;
    sw_upd_d  = 1'b0;
    btn_upd_d = 1'b0;
    err_d     = 1'b0;

    if (ena && rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == CH_S || rx_byte == CH_B) begin
            cmd_sw_d = (rx_byte == CH_S);
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_DIGITS;
          end else if (!is_term) begin
            // Blank lines and CRLF pairs are silently skipped
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end

        ST_DIGITS: begin
          if (is_hex) begin
            acc_d = {acc_q[ACC_W-5:0], nibble};
            cnt_d = cnt_inc;
            if (cnt_inc == n_digits) begin
              state_d = ST_TERM;
            end
          end else begin
            // An early terminator already ends the line, so no discard needed
            err_d   = 1'b1;
            state_d = is_term ? ST_IDLE : ST_DISCARD;
          end
        end

        ST_TERM: begin
          if (is_term) begin
            state_d = ST_IDLE;
            if (cmd_sw_q) begin
              if (sw_in_range) begin
                switch_d = acc_q[SWITCH_COUNT-1:0];
                sw_upd_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              if (btn_in_range) begin
                button_d  = acc_q[BUTTON_COUNT-1:0];
                btn_upd_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end

        ST_DISCARD: begin
          if (is_term) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset wins over ena
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      cmd_sw_q  <= 1'b0;
      switch_q  <= '0;
      button_q  <= '0;
      sw_upd_q  <= 1'b0;
      btn_upd_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      cmd_sw_q  <= cmd_sw_d;
      switch_q  <= switch_d;
      button_q  <= button_d;
      sw_upd_q  <= sw_upd_d;
      btn_upd_q <= btn_upd_d;
      err_q     <= err_d;
    end
  end

  assign switch_data = switch_q;
  assign button_data = button_q;
  assign sw_update   = sw_upd_q;
  assign btn_update  = btn_upd_q;
  assign cmd_error   = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: frames are streamed back-to-back, each
// expected strobe (kind, cycle, image values) is queued as the byte that
// causes it is sent, and a monitor pops and compares on every strobe.
module tb_uart_cmd_parser;

  localparam int KIND_SW  = 0;
  localparam int KIND_BTN = 1;
  localparam int KIND_ERR = 2;

  typedef struct {
    int          kind;
    logic [15:0] sw;
    logic [4:0]  btn;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] switch_data;
  logic [4:0]  button_data;
  logic        sw_update;
  logic        btn_update;
  logic        cmd_error;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          done = 1'b0;
  ev_t         exp_q[$];
  logic [15:0] m_sw = 16'h0000;
  logic [4:0]  m_btn = 5'h00;

  uart_cmd_parser #(
    .DATA_WIDTH  (8),
    .SWITCH_COUNT(16),
    .BUTTON_COUNT(5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .switch_data(switch_data),
    .button_data(button_data),
    .sw_update  (sw_update),
    .btn_update (btn_update),
    .cmd_error  (cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream a string back-to-back; byte index 'mark' queues one expected strobe
  task automatic send_str(input string s, input int mark, input int kind);
    for (int i = 0; i < s.len(); i++) begin
      rx_data  = s[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == mark) exp_q.push_back('{kind, m_sw, m_btn, cyc});
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({switch_data, button_data, sw_update, btn_update, cmd_error} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_values: sw=%h btn=%h strobes=%b%b%b required all zero",
               switch_data, button_data, sw_update, btn_update, cmd_error);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_switch_frame();
    m_sw = 16'h1234;
    send_str("S1234\n", 5, KIND_SW);
    n_checks++;
    if (exp_q.size() != 0 || switch_data !== m_sw || button_data !== m_btn) begin
      n_fail++;
      $display("FAIL switch_frame: pending=%0d sw=%h btn=%h required pending=0 sw=%h btn=%h",
               exp_q.size(), switch_data, button_data, m_sw, m_btn);
      exp_q.delete();
    end
  endtask

  task automatic test_button_crlf();
    m_btn = 5'h1F;
    send_str("B1f\r\n", 3, KIND_BTN);
    n_checks++;
    if (exp_q.size() != 0 || switch_data !== m_sw || button_data !== m_btn) begin
      n_fail++;
      $display("FAIL button_crlf: pending=%0d sw=%h btn=%h required pending=0 sw=%h btn=%h",
               exp_q.size(), switch_data, button_data, m_sw, m_btn);
      exp_q.delete();
    end
  endtask

  task automatic test_errors();
    // Out-of-range button value, bad digit, fifth digit, stray byte, early terminator
    send_str("B20\n", 3, KIND_ERR);
    send_str("S12G4\n", 3, KIND_ERR);
    m_sw = 16'hABCD;
    send_str("SABCD\n", 5, KIND_SW);
    send_str("S12345\n", 5, KIND_ERR);
    m_sw = 16'h0001;
    send_str("S0001\n", 5, KIND_SW);
    send_str("x\n", 0, KIND_ERR);
    send_str("S1\n", 2, KIND_ERR);
    send_str("\r\n\n", -1, KIND_ERR);
    m_btn = 5'h00;
    send_str("B00\n", 3, KIND_BTN);
    n_checks++;
    if (exp_q.size() != 0 || switch_data !== m_sw || button_data !== m_btn) begin
      n_fail++;
      $display("FAIL error_frames: pending=%0d sw=%h btn=%h required pending=0 sw=%h btn=%h",
               exp_q.size(), switch_data, button_data, m_sw, m_btn);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    send_str("S12", -1, KIND_ERR);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_sw  = 16'h0000;
    m_btn = 5'h00;
    send_str("34\n", 0, KIND_ERR);
    n_checks++;
    if (exp_q.size() != 0 || switch_data !== m_sw || button_data !== m_btn) begin
      n_fail++;
      $display("FAIL reset_mid_frame: pending=%0d sw=%h btn=%h required pending=0 sw=%h btn=%h",
               exp_q.size(), switch_data, button_data, m_sw, m_btn);
      exp_q.delete();
    end
  endtask

  task automatic test_enable_hold();
    send_str("S12", -1, KIND_ERR);
    ena = 1'b0;
    send_str("99\n", -1, KIND_ERR);
    n_checks++;
    if (switch_data !== m_sw || button_data !== m_btn) begin
      n_fail++;
      $display("FAIL enable_hold_images: sw=%h btn=%h required sw=%h btn=%h",
               switch_data, button_data, m_sw, m_btn);
    end
    ena = 1'b1;
    m_sw = 16'h1234;
    send_str("34\n", 2, KIND_SW);
    n_checks++;
    if (exp_q.size() != 0 || switch_data !== m_sw || button_data !== m_btn) begin
      n_fail++;
      $display("FAIL enable_resume: pending=%0d sw=%h btn=%h required pending=0 sw=%h btn=%h",
               exp_q.size(), switch_data, button_data, m_sw, m_btn);
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      begin : monitor
        int  k;
        ev_t e;
        while (!done) begin
          @(negedge clk);
          if (sw_update || btn_update || cmd_error) begin
            n_checks++;
            if ($countones({sw_update, btn_update, cmd_error}) > 1) begin
              n_fail++;
              $display("FAIL strobe_exclusive: strobes=%b%b%b required at most one high",
                       sw_update, btn_update, cmd_error);
            end
            k = sw_update ? KIND_SW : (btn_update ? KIND_BTN : KIND_ERR);
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_strobe: kind=%0d cycle=%0d required no strobe", k, cyc);
            end else begin
              e = exp_q.pop_front();
              if (k !== e.kind || cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL strobe_timing: kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                         k, cyc, e.kind, e.cyc);
              end
              n_checks++;
              if (switch_data !== e.sw || button_data !== e.btn) begin
                n_fail++;
                $display("FAIL strobe_images: sw=%h btn=%h required sw=%h btn=%h",
                         switch_data, button_data, e.sw, e.btn);
              end
            end
          end
        end
      end
      begin : stimulus
        test_reset();
        test_switch_frame();
        test_button_crlf();
        test_errors();
        test_reset_mid_frame();
        test_enable_hold();
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser sitting directly downstream of the `uart` receiver. It consumes `rx_data`/`rx_valid` and decodes ASCII frames into registered switch and button images for the Basys3 link. Valid frames update the images and raise one-cycle update strobes. Malformed frames are discarded whole and flagged on a one-cycle error strobe.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width. Only 8 is supported.
- `SWITCH_COUNT`, 16: width of the switch image. Must be 1..16.
- `BUTTON_COUNT`, 5: width of the button image. Must be 1..8.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  design enable. When low, all state holds, `rx_valid` is ignored and strobes are 0.
- `rx_data`  in  DATA_WIDTH  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `switch_data`  out  SWITCH_COUNT  registered switch image.
- `button_data`  out  BUTTON_COUNT  registered button image.
- `sw_update`  out  1  one-cycle pulse when `switch_data` is written.
- `btn_update`  out  1  one-cycle pulse when `button_data` is written.
- `cmd_error`  out  1  one-cycle pulse when a frame is rejected.

## Operation
Frame format:
- Command letter: `S` (0x53) or `B` (0x42), uppercase only.
- Then exactly N hex digits, MSB first: N=4 for `S`, N=2 for `B`. Hex digits are `0-9`, `A-F` and `a-f`.
- Then one terminator: LF (0x0A) or CR (0x0D).

State machine (2-bit state), with a 16-bit accumulator `acc` and a 3-bit digit counter `cnt`:
- IDLE:
  - `S` or `B`: latch the command, set `acc`=0 and `cnt`=0, go to DIGITS.
  - CR or LF: ignored, stay in IDLE. Empty lines and CRLF pairs are legal.
  - Any other byte: pulse `cmd_error`, go to DISCARD.
- DIGITS:
  - Hex digit: `acc` <= {`acc`[11:0], nibble}, `cnt`++. When `cnt` reaches N, go to TERM.
  - Any non-hex byte, including a terminator: pulse `cmd_error`. A terminator returns to IDLE; any other byte goes to DISCARD.
- TERM:
  - Terminator with `acc` ≤ 2^width−1: commit the frame, return to IDLE. Width is SWITCH_COUNT for `S` and BUTTON_COUNT for `B`.
    - `S`: `switch_data` <= `acc`[SWITCH_COUNT−1:0] and pulse `sw_update`.
    - `B`: `button_data` <= `acc`[BUTTON_COUNT−1:0] and pulse `btn_update`.
  - Terminator with `acc` out of range: pulse `cmd_error`, no commit, return to IDLE.
  - Any other byte (for example a fifth digit): pulse `cmd_error`, go to DISCARD.
- DISCARD:
  - Drop bytes until a CR or LF is received, then go to IDLE.
  - No further `cmd_error` pulses for the same frame.

Invariants:
- At most one of `sw_update`, `btn_update`, `cmd_error` is high in any cycle.
- Only one byte is processed per `rx_valid`. Back-to-back `rx_valid` on consecutive cycles must be accepted without loss.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - state=IDLE, `acc`=0, `cnt`=0.
  - `switch_data`=0, `button_data`=0, `sw_update`=`btn_update`=`cmd_error`=0.
  - Reset mid-frame discards the partial frame; nothing is committed.
- Latency: a byte with `rx_valid` high at edge k is acted on at edge k.
  - The image register and its strobe become visible after edge k.
  - A terminator at edge k therefore gives a new `switch_data` and `sw_update`=1 in cycle k+1. Strobes last exactly one cycle.
- Image registers hold their value between commits, independent of later errors.
- `ena`=0 and `rx_valid`=1 in the same cycle: the byte is dropped, and parsing continues from the held state when `ena` returns.
- Reset has priority over `ena`.

## Test plan
- Reset, then send "S1234\n" with back-to-back `rx_valid` → `switch_data`=0x1234 and `sw_update` high for exactly 1 cycle, one cycle after the LF. `button_data` stays 0.
- Send "B1f\r\n" → `button_data`=5'h1F and one `btn_update` pulse. The trailing LF is ignored: no error, no extra strobe.
- Send "B20\n" → one `cmd_error` pulse on the LF. `button_data` keeps its prior value; no `btn_update`.
- Send "S12G4\n" then "SABCD\n" → one `cmd_error` on 'G', DISCARD through the LF, then `switch_data`=0xABCD.
- Send "S12345\n" → `cmd_error` on '5'. `switch_data` unchanged. The next "S0001\n" gives 0x0001.
- Send "S12", assert `reset_n`=0 for 1 cycle, then send "34\n" → no update. The '3' gives one `cmd_error` and the parser discards through the LF. With `ena`=0, bytes presented must produce no state change.
